// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing defaults and helpers for the register bank with pending-write scoreboard.
package regfile_scoreboard_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned R0        = 0;

  // Address width for a bank of n registers; never narrower than one bit.
  function automatic int unsigned aw_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_pend_cnt.sv
// Saturating up/down counter tracking outstanding writes to one register.
module rf_pend_cnt #(
  parameter int unsigned W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic sat,
  output logic zero,
  output logic one
);

  logic [W-1:0] cnt;

  // Clear wins; simultaneous inc and dec cancel; ends of range hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec && !sat) begin
      cnt <= cnt + W'(1);
    end else if (dec && !inc && !zero) begin
      cnt <= cnt - W'(1);
    end
  end

  assign sat  = (cnt == {W{1'b1}});
  assign zero = (cnt == '0);
  assign one  = (cnt == W'(1));

endmodule

// File: rtl/regfile_scoreboard.sv
// Register bank with write-through bypass and per-register pending-write scoreboard.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter  int unsigned XLEN   = XLEN_DEF,
  parameter  int unsigned NREGS  = NREGS_DEF,
  parameter  int unsigned NREAD  = 3,
  parameter  int unsigned PEND_W = 2,
  localparam int unsigned AW     = aw_of(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  output logic                  iss_ready,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  flush,
  output logic                  err_underflow
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] sat_v;
  logic [NREGS-1:0] zero_v;
  logic [NREGS-1:0] one_v;
  logic             flushed;
  logic             wr_live;

  assign wr_live = wr_en && (wr_addr != AW'(R0));

  // Register 0 never counts: permanently idle, never saturated.
  assign sat_v[0]  = 1'b0;
  assign zero_v[0] = 1'b1;
  assign one_v[0]  = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        regs[r] <= '0;
      end
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign iss_ready = !((iss_addr != AW'(R0)) && sat_v[iss_addr] &&
                       !(wr_en && (wr_addr == iss_addr)));

  for (genvar r = 1; r < int'(NREGS); r++) begin : g_cnt
    logic inc;
    logic dec;
    assign inc = iss_en && iss_ready && (iss_addr == AW'(r));
    assign dec = wr_en && (wr_addr == AW'(r)) && !zero_v[r];
    rf_pend_cnt #(.W(PEND_W)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc),
      .dec  (dec),
      .clr  (flush),
      .sat  (sat_v[r]),
      .zero (zero_v[r]),
      .one  (one_v[r])
    );
  end

  // A retire landing this cycle is forwarded, so its final retire is not a hazard.
  for (genvar i = 0; i < int'(NREAD); i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    assign ra  = rd_addr[i*AW +: AW];
    assign hit = wr_en && (wr_addr == ra) && (ra != AW'(R0));
    assign rd_data[i*XLEN +: XLEN] = hit ? wr_data : regs[ra];
    assign rd_busy[i] = (ra != AW'(R0)) && !zero_v[ra] && !(one_v[ra] && hit);
  end

  // Retires after a flush legitimately hit zero, so the error only arms until the first flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flushed       <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (flush) begin
        flushed <= 1'b1;
      end
      if (wr_live && zero_v[wr_addr] && !flush && !flushed) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule
